// File: rtl/hs_inband_sched.sv
// Inband command-ring scheduler: fetches pending descriptors over the read master,
// dispatches them to one of four port engines and writes the consumer index back.
module hs_inband_sched #(
    parameter int C_DESC_WORDS   = 8,
    parameter int C_RING_ENTRIES = 256
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ring_enable,
    input  logic [31:0] inband_base,
    input  logic [31:0] inband_cons_addr,
    input  logic [11:0] inband_prod_index,
    output logic [11:0] inband_cons_index,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    input  logic        rd_last,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ack,
    output logic [3:0]  desc_valid,
    output logic [31:0] desc_data,
    output logic        desc_last,
    input  logic [3:0]  desc_ready,
    output logic        sched_err,
    output logic [31:0] sched_state
);

    localparam int          IDX_W     = $clog2(C_RING_ENTRIES);
    localparam int          WORD_W    = $clog2(C_DESC_WORDS);
    localparam int          ADDR_SH   = WORD_W + 2;
    localparam logic [11:0] IDX_MASK  = 12'((1 << IDX_W) - 1);
    localparam logic [7:0]  LAST_WORD = 8'(C_DESC_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_DATA  = 3'd2,
        S_DISPATCH = 3'd3,
        S_WB_REQ   = 3'd4,
        S_DRAIN    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] cons_q, cons_d;
    logic        err_q, err_d;
    logic        bad_q, bad_d;
    logic        buf_we;
    logic [31:0] buf_q [C_DESC_WORDS];

    logic [1:0]  port;
    logic        port_ready;
    logic        pending;
    logic        word_ok;

    assign port       = buf_q[0][1:0];
    assign port_ready = desc_ready[port];
    assign pending    = (inband_prod_index & IDX_MASK) != cons_q;
    assign word_ok    = rd_last ? (cnt_q == LAST_WORD) : (cnt_q < LAST_WORD);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cons_q  <= 12'd0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cons_q  <= cons_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    // NOTE: the descriptor buffer has no reset; its contents are only read after
    // a full burst has overwritten them, so a reset would buy nothing.
    always_ff @(posedge sys_clk) begin
        if (buf_we) begin
            buf_q[cnt_q[WORD_W-1:0]] <= rd_data;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cons_d  = cons_q;
        err_d   = err_q;
        bad_d   = bad_q;
        buf_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!ring_enable) begin
                    cons_d = 12'd0;
                end else if (pending) begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                cnt_d = 8'd0;
                bad_d = 1'b0;
                if (rd_ack) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rd_valid) begin
                    buf_we = (cnt_q <= LAST_WORD);
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (!word_ok) begin
                        err_d = 1'b1;
                        bad_d = 1'b1;
                    end
                    // A malformed burst is absorbed to its end and then discarded.
                    if (rd_last) begin
                        if (!word_ok || bad_q) begin
                            state_d = S_IDLE;
                        end else if (!ring_enable) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_DISPATCH;
                            cnt_d   = 8'd0;
                        end
                    end
                end
            end
            S_DISPATCH: begin
                if (port_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_WB_REQ;
                        cnt_d   = 8'd0;
                        cons_d  = (cons_q + 12'd1) & IDX_MASK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_WB_REQ: begin
                if (wr_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_req     = 1'b0;
        rd_addr    = 32'd0;
        wr_req     = 1'b0;
        wr_addr    = 32'd0;
        wr_data    = 32'd0;
        desc_valid = 4'd0;
        desc_data  = 32'd0;
        desc_last  = 1'b0;
        case (state_q)
            S_RD_REQ: begin
                rd_req  = 1'b1;
                rd_addr = inband_base + (32'(cons_q) << ADDR_SH);
            end
            S_DISPATCH: begin
                desc_valid = 4'b0001 << port;
                desc_data  = buf_q[cnt_q[WORD_W-1:0]];
                desc_last  = (cnt_q == LAST_WORD);
            end
            S_WB_REQ: begin
                wr_req  = 1'b1;
                wr_addr = inband_cons_addr;
                wr_data = {20'd0, cons_q};
            end
            default: begin
            end
        endcase
    end

    assign inband_cons_index = cons_q;
    assign sched_err         = err_q;
    assign sched_state       = {cons_q, 4'b0000, cnt_q, 5'b00000, state_q};

endmodule

// File: tb/tb_hs_inband_sched.sv
// Scoreboard bench for hs_inband_sched: stimulus pushes expected reads, descriptor
// words and writebacks; a negedge monitor pops and compares as the DUT presents them.
module tb_hs_inband_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        ring_enable;
    logic [31:0] inband_base;
    logic [31:0] inband_cons_addr;
    logic [11:0] inband_prod_index;
    logic [11:0] inband_cons_index;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [3:0]  desc_valid;
    logic [31:0] desc_data;
    logic        desc_last;
    logic [3:0]  desc_ready;
    logic        sched_err;
    logic [31:0] sched_state;

    always #5 sys_clk = ~sys_clk;

    hs_inband_sched #(.C_DESC_WORDS(8), .C_RING_ENTRIES(256)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ring_enable(ring_enable),
        .inband_base(inband_base), .inband_cons_addr(inband_cons_addr),
        .inband_prod_index(inband_prod_index), .inband_cons_index(inband_cons_index),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_last(rd_last), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .desc_valid(desc_valid),
        .desc_data(desc_data), .desc_last(desc_last), .desc_ready(desc_ready),
        .sched_err(sched_err), .sched_state(sched_state)
    );

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        last;
    } desc_t;

    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam logic [31:0] CONS_ADDR = 32'h2000_0400;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;
    int bad_hot  = 0;
    int xfer_cnt = 0;
    int stall_trigger = -1;
    int stall_left    = 0;
    bit ready_block   = 1'b0;

    logic [31:0] exp_rd_q[$];
    desc_t       exp_desc_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] word_q[$];
    int          len_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Queue one burst for the memory model plus everything the DUT should emit for it.
    task automatic issue(input logic [11:0] idx, input logic [1:0] port, input int len,
                         input bit disp, input logic [11:0] new_cons);
        logic [31:0] w;
        exp_rd_q.push_back(BASE + 32'(idx) * 32'd32);
        len_q.push_back(len);
        for (int i = 0; i < len; i++) begin
            w = (i == 0) ? {20'hA5A5A ^ 20'(idx), 10'h0, port}
                         : {4'hD, 8'(idx), 12'h0, 8'(i)};
            word_q.push_back(w);
            if (disp) exp_desc_q.push_back('{valid: 4'b0001 << port, data: w, last: (i == len - 1)});
        end
        if (disp) exp_wr_q.push_back({CONS_ADDR, 20'd0, new_cons});
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge sys_clk);
            done = (sched_state[2:0] == 3'd0) && exp_rd_q.size() == 0 &&
                   exp_desc_q.size() == 0 && exp_wr_q.size() == 0 && len_q.size() == 0;
        end
        check(name, 64'(done), 64'd1);
        @(negedge sys_clk);
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge sys_clk);
            done = (sched_state[2:0] == st);
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Read-port memory model: one-cycle ack, then the queued burst one word per cycle.
    initial begin
        int n;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 32'd0; rd_last = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (rd_req && len_q.size() > 0) begin
                rd_ack = 1'b1;
                @(posedge sys_clk); #1;
                rd_ack = 1'b0;
                n = len_q.pop_front();
                for (int i = 0; i < n; i++) begin
                    rd_valid = 1'b1;
                    rd_data  = word_q.pop_front();
                    rd_last  = (i == n - 1);
                    @(posedge sys_clk); #1;
                end
                rd_valid = 1'b0; rd_last = 1'b0; rd_data = 32'd0;
            end
        end
    end

    initial begin
        wr_ack = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            wr_ack = wr_req && !wr_ack;
        end
    end

    initial begin
        desc_ready = 4'hF;
        forever begin
            @(posedge sys_clk); #1;
            if (xfer_cnt == stall_trigger) begin
                stall_left    = 5;
                stall_trigger = -1;
            end
            if (ready_block) desc_ready = 4'h0;
            else if (stall_left > 0) begin
                desc_ready = 4'b1101;
                stall_left--;
            end else desc_ready = 4'hF;
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (rd_req && wr_req) overlap++;
            if (desc_valid != 4'd0 && !$onehot(desc_valid)) bad_hot++;
            if (rd_req && rd_ack) begin
                if (exp_rd_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got read at 0x%08h expected none", rd_addr);
                end else check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
            end
            if ((desc_valid & desc_ready) != 4'd0) begin
                xfer_cnt++;
                if (exp_desc_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL desc_unexpected: got word 0x%08h valid %b expected none", desc_data, desc_valid);
                end else check("desc_word", 64'({desc_valid, desc_data, desc_last}),
                               64'(exp_desc_q.pop_front()));
            end
            if (wr_req && wr_ack) begin
                if (exp_wr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got write 0x%08h to 0x%08h expected none", wr_data, wr_addr);
                end else check("wb_write", {wr_addr, wr_data}, exp_wr_q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        sys_rst = 1'b1; ring_enable = 1'b0; inband_base = BASE;
        inband_cons_addr = CONS_ADDR; inband_prod_index = 12'd0;
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", {rd_req, wr_req, desc_valid, desc_last, sched_err, inband_cons_index}, 64'd0);
        check("reset_state", 64'(sched_state), 64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single descriptor to port 2.
        issue(12'd0, 2'd2, 8, 1'b1, 12'd1);
        ring_enable = 1'b1; inband_prod_index = 12'd1;
        wait_idle("t1_idle", 200);
        check("t1_cons", 64'(inband_cons_index), 64'd1);

        // Disable resets the index; three descriptors to port 1 with a mid-descriptor stall.
        ring_enable = 1'b0;
        @(negedge sys_clk); @(negedge sys_clk);
        check("disable_cons", 64'(inband_cons_index), 64'd0);
        for (int i = 0; i < 3; i++) issue(12'(i), 2'd1, 8, 1'b1, 12'(i + 1));
        stall_trigger = xfer_cnt + 11;
        inband_prod_index = 12'd3; ring_enable = 1'b1;
        wait_idle("t2_idle", 400);
        check("t2_cons", 64'(inband_cons_index), 64'd3);

        // Run up to index 255, then wrap to 0.
        for (int i = 3; i < 255; i++) issue(12'(i), 2'(i % 4), 8, 1'b1, 12'(i + 1));
        inband_prod_index = 12'd255;
        wait_idle("t3_idle", 20000);
        check("t3_cons255", 64'(inband_cons_index), 64'd255);
        issue(12'd255, 2'd3, 8, 1'b1, 12'd0);
        inband_prod_index = 12'd0;
        wait_idle("t3_wrap_idle", 200);
        check("t3_cons_wrap", 64'(inband_cons_index), 64'd0);

        // Short burst flags an error and is refetched; the good one still dispatches.
        issue(12'd0, 2'd0, 5, 1'b0, 12'd0);
        issue(12'd0, 2'd0, 8, 1'b1, 12'd1);
        inband_prod_index = 12'd1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge sys_clk);
            seen = sched_err;
        end
        check("err_set", 64'(seen), 64'd1);
        check("err_cons_held", 64'(inband_cons_index), 64'd0);
        wait_idle("t4_idle", 200);
        check("t4_cons", 64'(inband_cons_index), 64'd1);
        check("err_sticky", 64'(sched_err), 64'd1);

        // Disable during the read burst: absorbed, no dispatch, index forced to 0.
        issue(12'd1, 2'd2, 8, 1'b0, 12'd0);
        inband_prod_index = 12'd2;
        wait_state("t5_rd_data", 3'd2, 100);
        ring_enable = 1'b0;
        wait_idle("t5_idle", 200);
        check("t5_cons", 64'(inband_cons_index), 64'd0);

        // Asynchronous reset while the second descriptor is stuck in dispatch.
        issue(12'd0, 2'd0, 8, 1'b1, 12'd1);
        issue(12'd1, 2'd3, 8, 1'b0, 12'd0);
        ring_enable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge sys_clk);
            seen = (inband_cons_index == 12'd1);
        end
        check("t6_first_done", 64'(seen), 64'd1);
        ready_block = 1'b1;
        wait_state("t6_dispatch", 3'd3, 200);
        check("t6_valid_before", 64'(desc_valid), 64'b1000);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_outputs", {rd_req, wr_req, desc_valid, sched_err, inband_cons_index}, 64'd0);
        ring_enable = 1'b0; ready_block = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        check("no_req_overlap", 64'(overlap), 64'd0);
        check("desc_onehot", 64'(bad_hot), 64'd0);
        check("queues_empty", 64'(exp_rd_q.size() + exp_desc_q.size() + exp_wr_q.size() + len_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hs_inband_sched.md
Name: hs_inband_sched

Overview:
Inband command-ring scheduler. Watches the inband producer index written by the host through the DCR register file, fetches each pending descriptor from system memory over a single-master read port, and dispatches it to one of four SATA port engines. After each dispatch it advances the consumer index and writes it back to host memory at the inband consumer address. It sits between the DCR host interface block (ring configuration) and the per-port DMA engines, and shares the NPI read/write master.

Parameters:
C_DESC_WORDS, 8, descriptor length in 32-bit words (power of two, 2..16)
C_RING_ENTRIES, 256, ring depth in descriptors (power of two, <=4096); indices wrap modulo this value

Ports:
sys_clk  in  1  block clock
sys_rst  in  1  asynchronous active-high reset
ring_enable  in  1  ring on; while 0, the block idles and the consumer index is held at 0
inband_base  in  32  ring base byte address (descriptor 0)
inband_cons_addr  in  32  host byte address for consumer-index writeback
inband_prod_index  in  12  host producer index
inband_cons_index  out  12  current consumer index
rd_req  out  1  read burst request; held until rd_ack
rd_addr  out  32  burst byte address
rd_ack  in  1  request accepted (one-cycle pulse)
rd_valid  in  1  read data word valid
rd_data  in  32  read data
rd_last  in  1  last word of burst
wr_req  out  1  single-word write request; held until wr_ack
wr_addr  out  32  write byte address
wr_data  out  32  write data
wr_ack  in  1  write done (one-cycle pulse)
desc_valid  out  4  per-port descriptor word valid (one-hot or 0)
desc_data  out  32  descriptor word
desc_last  out  1  final word of the descriptor
desc_ready  in  4  per-port accept
sched_err  out  1  sticky burst-length error
sched_state  out  32  debug: {cons_index[11:0], 4'b0, word_cnt[7:0], 5'b0, state[2:0]}

Behaviour:
- Reset: all outputs 0, state IDLE, buffer contents don't-care.
- States: IDLE, RD_REQ, RD_DATA, DISPATCH, WB_REQ, DRAIN.
- IDLE: if ring_enable && inband_prod_index[11:0] != cons_index, go to RD_REQ next cycle. Only the low log2(C_RING_ENTRIES) bits of the indices are compared.
- RD_REQ: rd_req=1, rd_addr = inband_base + cons_index*C_DESC_WORDS*4 (32-bit, wraps). Both stay stable until rd_ack. Go to RD_DATA the cycle after rd_ack.
- RD_DATA: each rd_valid stores rd_data into buffer[word_cnt] and increments word_cnt.
  - rd_last on word C_DESC_WORDS-1: go to DISPATCH, or to DRAIN if ring_enable is 0.
  - rd_last early, or rd_valid without rd_last at or beyond word C_DESC_WORDS-1: sched_err<=1 (sticky until reset), descriptor discarded, index not advanced. Continue accepting words until rd_last, then go to IDLE.
- Target port = buffer[0][1:0].
- DISPATCH: desc_valid[port]=1 and desc_data=buffer[dcnt]. desc_last=1 when dcnt=C_DESC_WORDS-1. A word transfers when desc_ready[port]=1; dcnt advances one word per accepted cycle, and back-to-back words are allowed. After the last transfer go to WB_REQ. ring_enable falling during DISPATCH does not abort the dispatch.
- WB_REQ: cons_index becomes (cons_index+1) mod C_RING_ENTRIES on entry. wr_req=1, wr_addr=inband_cons_addr, wr_data={20'b0, new cons_index}. Go to IDLE after wr_ack.
- DRAIN: ring_enable dropped before dispatch. Descriptor discarded, no writeback, go to IDLE.
- Whenever ring_enable=0 and state is IDLE, cons_index is forced to 0.
- Wrap: index C_RING_ENTRIES-1 increments to 0, and the address computation wraps with it.
- rd_req and wr_req are never asserted together. Throughput: at most one descriptor outstanding.

Test Plan:
- Reset, ring_enable=1, base=0x1000_0000, prod=1, 8-word burst with word0=0x2 -> rd_addr=0x1000_0000; desc_valid=4'b0100 for 8 accepted words; desc_last on the 8th; write of 0x1 to cons_addr; inband_cons_index=1.
- prod=3 from cons=0, port 1 holds desc_ready low for 5 cycles mid-descriptor -> no word lost or duplicated; second rd_addr=base+0x20, third=base+0x40; final cons=3.
- cons=255 (C_RING_ENTRIES=256), prod=0 -> fetch from base+255*32; cons wraps to 0; wr_data=0x0.
- rd_last on the 5th word -> sched_err=1, no desc_valid, cons unchanged; a following good burst still dispatches and sched_err stays 1.
- ring_enable dropped during RD_DATA -> burst absorbed, no dispatch, no write; cons reads 0 once IDLE.
- sys_rst asserted in DISPATCH -> desc_valid, rd_req, wr_req and cons_index are 0 immediately (asynchronous).
